// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM states, parity modes and the clog2 helper shared by the UART blocks.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_tick_edge_detect.sv
// tick_edge_detect: one-cycle pulse per rising edge of level; a level already high
// when reset is released does not count as an edge.
module tick_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level_q <= 1'b1;
        else          level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, LSB-first serial frame out (start, data, optional parity, stop),
// with every bit boundary aligned to a baud tick event.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int TICKS_PER_BIT = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int TW = (clog2(TICKS_PER_BIT) < 1) ? 1 : clog2(TICKS_PER_BIT);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick_ev, last;

    tick_edge_detect u_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .level  (baud_tick),
        .pulse  (tick_ev)
    );

    assign last = tick_ev && (tick_cnt_q == TW'(TICKS_PER_BIT - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        done_d     = 1'b0;
        if (state_q != ST_IDLE && state_q != ST_SYNC && tick_ev)
            tick_cnt_d = last ? '0 : tick_cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: if (tx_valid) begin
                shift_d = tx_data;
                par_d   = (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
                state_d = ST_SYNC;
            end
            ST_SYNC: if (tick_ev) begin
                tick_cnt_d = '0;
                state_d    = ST_START;
            end
            ST_START: if (last) begin
                bit_cnt_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: if (last) begin
                if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                    stop_cnt_d = 1'b0;
                    state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = shift_q >> 1;
                end
            end
            ST_PARITY: if (last) begin
                stop_cnt_d = 1'b0;
                state_d    = ST_STOP;
            end
            ST_STOP: if (last) begin
                if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // line level is registered from the next state so it changes one clk after the event
        tx_d   = (state_d == ST_START)  ? 1'b0 :
                 (state_d == ST_DATA)   ? shift_d[0] :
                 (state_d == ST_PARITY) ? par_q : 1'b1;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter directly downstream of the baud tick generator; consumes its tick output to time each bit.
- Accepts one parallel byte per valid/ready handshake and shifts out a frame on tx, LSB first: start, data, optional parity, stop.
- Used to return recognition results and debug data from the FPGA to the host.

Parameters:
- DATA_BITS, 8: data bits per frame, range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- TICKS_PER_BIT, 2: tick events per bit period; the generator runs at 2x baudrate.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- baud_tick  in  1  tick from the generator; may stay high for several clk cycles.
- tx_data  in  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a byte.
- tx  out  1  serial line, idles high.
- busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Tick edge detect:
  - tick_event = baud_tick & ~tick_d; tick_d resets to 1.
  - Exactly one event per rising edge, regardless of pulse width.
  - A tick already high at reset release is not an event.
- Reset (async, immediate): state IDLE, tx=1, busy=0, tx_done=0, counters 0, tick_d=1.
- tx_ready is combinational (state==IDLE), so it reads 1 during reset.
- States and transitions:
  - IDLE: tx=1. On tx_valid & tx_ready, latch tx_data into shift_reg, compute parity, go to SYNC.
  - SYNC: tx=1. On tick_event, drive tx=0 (registered), clear tick_cnt, go to START. This aligns every bit boundary to a tick event.
  - START, DATA, PARITY, STOP: on each tick_event, tick_cnt++. When tick_cnt==TICKS_PER_BIT-1 and tick_event occur, clear tick_cnt and advance one bit.
  - DATA: tx=shift_reg[0]; shift right per bit; bit_cnt counts 0..DATA_BITS-1.
  - PARITY: entered only if PARITY!=0. Odd: tx = ~^data. Even: tx = ^data.
  - STOP: tx=1 for STOP_BITS bit periods. At the end, go to IDLE and pulse tx_done for exactly one cycle.
- Bit timing: every bit lasts exactly TICKS_PER_BIT tick periods. tx changes one clk after the tick_event.
- busy = (state != IDLE), registered.
- Back-to-back frames: tx_ready is 1 in the same cycle tx_done pulses. A new accept there yields an idle-high gap of exactly one tick period before the next start bit.
- Ignored inputs:
  - tx_valid while not ready: no accept.
  - tx_data changes after accept: no effect.
  - tx_valid dropping mid-frame: frame still completes.
- Reset mid-frame: frame aborted; tx=1 immediately; no tx_done.
- Width rules:
  - tick_cnt is clog2(TICKS_PER_BIT) bits, minimum 1.
  - bit_cnt is 3 bits; stop_cnt is 1 bit.
  - No wrap-around beyond terminal counts.

Decomposition:
- Shared header uart_defs.vh holds:
  - state encodings (IDLE, SYNC, START, DATA, PARITY, STOP);
  - parity constants PARITY_NONE/ODD/EVEN;
  - the clog2 function.
- One sub-module, tick_edge_detect: input clk, reset_n, level; output pulse. uart_rx reuses it later.

Test Plan:
Bench clock setup: the tick is a 2-cycle-high pulse every 20 clk, so one bit = 40 clk.
- Defaults, send 0x55 -> tx is start 0 then 1,0,1,0,1,0,1,0 then stop 1, each level 40 clk. Frame is 400 clk. One tx_done pulse. busy falls with it.
- PARITY=2, send 0x07 -> parity bit 1. With PARITY=1, same byte -> parity bit 0. Frame is 440 clk.
- Send 0xA5 then 0x3C with tx_valid held -> exactly 20 clk of high between end of first stop and second start. Both bytes correct, LSB first.
- tx_valid pulsed with 0xFF mid-frame while tx_ready=0 -> no accept; current frame unchanged; 0xFF never transmitted.
- reset_n low during data bit 3 -> tx=1 asynchronously, busy=0, no tx_done. After release, 0x3C transmits correctly.
- STOP_BITS=2; baud_tick held high 5 cycles per pulse -> stop high 80 clk; one event per pulse; bit widths stay 40 clk.
